// File: rtl/nts_bram_pkg.sv
// Shared definitions for the arbitrated BRAM: FSM encoding and grant-index width.
package nts_bram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  // Width of a client index; a single client still needs a 1-bit index.
  function automatic int grant_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_arb_with_ack_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one above the last
// granted index and wraps; the last-grant pointer is held by the parent.
module rr_arbiter
  import nts_bram_pkg::*;
#(
  parameter int N = 2,
  parameter int W = grant_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  input  logic         update,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  logic        found;
  int unsigned idx;

  // First requester found walking upward from last+1 wins; nothing wins without update.
  always_comb begin
    grant     = '0;
    grant_idx = last;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      if (update && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = W'(idx);
      end
    end
  end

endmodule

// File: rtl/bram_arb_with_ack.sv
// Single-port BRAM shared by NUM_CLIENTS requesters via round-robin arbitration,
// with a cs/we/ack handshake per client and a shared read-data bus.
module bram_arb_with_ack
  import nts_bram_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                              clk,
  input  logic                              areset,
  input  logic [NUM_CLIENTS-1:0]            cs,
  input  logic [NUM_CLIENTS-1:0]            we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_CLIENTS-1:0]            ack,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic                              busy,
  output logic [grant_width(NUM_CLIENTS)-1:0] grant_id
);

  localparam int          GW     = grant_width(NUM_CLIENTS);
  localparam logic [7:0]  WAIT_L = 8'(WAIT_CYCLES);

  state_t                  state;
  logic [7:0]              cnt;
  logic                    lat_we;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  logic [NUM_CLIENTS-1:0]  arb_grant;
  logic [GW-1:0]           arb_idx;
  logic                    do_access;

  rr_arbiter #(
    .N (NUM_CLIENTS),
    .W (GW)
  ) u_arb (
    .req       (cs),
    .last      (grant_id),
    .update    (state == IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // The memory access edge: last ACCESS cycle once the wait count is reached.
  always_comb begin
    do_access = (state == ACCESS) && (cnt == WAIT_L);
  end

  // Memory array is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!areset && do_access && lat_we) begin
      mem[lat_addr] <= lat_wdata;
    end
  end

  // Grant / wait / acknowledge sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (areset) begin
      state     <= IDLE;
      cnt       <= '0;
      ack       <= '0;
      rd_data   <= '0;
      busy      <= 1'b0;
      grant_id  <= GW'(NUM_CLIENTS - 1);
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|arb_grant) begin
            lat_we    <= we[arb_idx];
            lat_addr  <= addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            lat_wdata <= wr_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
            grant_id  <= arb_idx;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (do_access) begin
            // Non-blocking read of the array returns the pre-write word.
            rd_data <= mem[lat_addr];
            ack     <= NUM_CLIENTS'(1) << grant_id;
            state   <= ACK;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ACK: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_arb_with_ack.sv
// Self-checking bench: three DUT instances (WAIT_CYCLES 0, 2, 3) driven by
// directed and random transactions, checked against a behavioural memory model.
module tb_bram_arb_with_ack;

  localparam int NC = 2;
  localparam int AW = 4;
  localparam int DW = 128;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             areset_a [NI];
  logic [NC-1:0]    cs_a     [NI];
  logic [NC-1:0]    we_a     [NI];
  logic [NC*AW-1:0] addr_a   [NI];
  logic [NC*DW-1:0] wd_a     [NI];
  logic [NC-1:0]    ack_a    [NI];
  logic [DW-1:0]    rd_a     [NI];
  logic             busy_a   [NI];
  logic [0:0]       gid_a    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WC = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    bram_arb_with_ack #(
      .NUM_CLIENTS (NC),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .WAIT_CYCLES (WC)
    ) dut (
      .clk      (clk),
      .areset   (areset_a[g]),
      .cs       (cs_a[g]),
      .we       (we_a[g]),
      .addr     (addr_a[g]),
      .wr_data  (wd_a[g]),
      .ack      (ack_a[g]),
      .rd_data  (rd_a[g]),
      .busy     (busy_a[g]),
      .grant_id (gid_a[g])
    );
  end

  // Reference model: memory image, written-flags and last granted client.
  logic [DW-1:0] mem_m   [NI][16];
  bit            known_m [NI][16];
  int            last_m  [NI];

  int total = 0;
  int bad   = 0;

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Round-robin rule: first requester above the last grant, with wrap.
  function automatic int pick(input logic [NC-1:0] req, input int last);
    for (int off = 1; off <= NC; off++) begin
      if (req[(last + off) % NC]) return (last + off) % NC;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k);
    areset_a[k] = 1'b1;
    cs_a[k]     = '0;
    we_a[k]     = '0;
    step();
    step();
    areset_a[k] = 1'b0;
    last_m[k]   = NC - 1;
    chk("rst_ack", ack_a[k], 0);
    chk("rst_rd", rd_a[k], 0);
    chk("rst_busy", busy_a[k], 0);
    chk("rst_gid", gid_a[k], NC - 1);
  endtask

  // One transaction from an idle DUT; drop_early releases cs right after the grant.
  task automatic txn(input int k, input int c, input bit w, input int a,
                     input logic [DW-1:0] d, input bit drop_early);
    logic [DW-1:0] exp_rd;
    logic [NC-1:0] oh;
    bit            exp_known;
    int            n;
    int            busy_n;
    bit            seen;
    exp_rd    = mem_m[k][a];
    exp_known = known_m[k][a];
    oh        = NC'(1) << c;
    cs_a[k][c]               = 1'b1;
    we_a[k][c]               = w;
    addr_a[k][c*AW +: AW]    = AW'(a);
    wd_a[k][c*DW +: DW]      = d;
    n = 0; busy_n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (busy_a[k]) busy_n++;
      if (drop_early && n == 1) begin
        cs_a[k][c]            = 1'b0;
        we_a[k][c]            = ~w;
        addr_a[k][c*AW +: AW] = ~AW'(a);
        wd_a[k][c*DW +: DW]   = ~d;
      end
      chk("ack_other", ack_a[k] & ~oh, 0);
      if (ack_a[k] != '0) seen = 1'b1;
    end
    chk("ack_onehot", ack_a[k], oh);
    chk("latency", n, wc(k) + 2);
    chk("busy_cycles", busy_n, wc(k) + 2);
    chk("grant_id", gid_a[k], c);
    if (exp_known) chk("rd_data", rd_a[k], exp_rd);
    cs_a[k][c] = 1'b0;
    step();
    chk("ack_fall", ack_a[k], 0);
    chk("busy_fall", busy_a[k], 0);
    if (exp_known) chk("rd_hold", rd_a[k], exp_rd);
    if (w) begin
      mem_m[k][a]   = d;
      known_m[k][a] = 1'b1;
    end
    last_m[k] = c;
  endtask

  // Both clients request continuously, 4 reads each, on instance k.
  task automatic fairness(input int k);
    int            done_n [NC];
    int            ca     [NC];
    int            exp_c;
    int            guard;
    logic [NC-1:0] req;
    ca[0] = 3; ca[1] = 5;
    for (int c = 0; c < NC; c++) begin
      done_n[c]             = 0;
      cs_a[k][c]            = 1'b1;
      we_a[k][c]            = 1'b0;
      addr_a[k][c*AW +: AW] = AW'(ca[c]);
    end
    for (int t = 0; t < 2 * 4; t++) begin
      req   = cs_a[k];
      exp_c = pick(req, last_m[k]);
      guard = 0;
      do begin
        step();
        guard++;
        chk("ack_overlap", ($countones(ack_a[k]) <= 1), 1);
      end while (ack_a[k] == '0 && guard < 40);
      chk("rr_gid", gid_a[k], exp_c);
      chk("rr_ack", ack_a[k], NC'(1) << exp_c);
      chk("rr_rd", rd_a[k], mem_m[k][ca[exp_c]]);
      last_m[k] = exp_c;
      done_n[exp_c]++;
      if (done_n[exp_c] == 4) begin
        cs_a[k][exp_c] = 1'b0;
      end else begin
        ca[exp_c] = (ca[exp_c] == 3) ? 5 : 3;
        addr_a[k][exp_c*AW +: AW] = AW'(ca[exp_c]);
      end
    end
    step();
    chk("rr_idle", busy_a[k], 0);
  endtask

  initial begin
    logic [DW-1:0] a5;
    logic [DW-1:0] old2;
    for (int k = 0; k < NI; k++) begin
      areset_a[k] = 1'b1;
      cs_a[k]     = '0;
      we_a[k]     = '0;
      addr_a[k]   = '0;
      wd_a[k]     = '0;
      last_m[k]   = NC - 1;
      for (int a = 0; a < 16; a++) known_m[k][a] = 1'b0;
    end
    for (int k = 0; k < NI; k++) do_reset(k);

    // WAIT_CYCLES=0: basic write/read, read-before-write, early cs drop.
    a5 = {16{8'hA5}};
    txn(0, 0, 1'b1, 3, a5, 1'b0);
    txn(0, 0, 1'b0, 3, rnd128(), 1'b0);
    chk("read_a5", rd_a[0], a5);
    txn(0, 0, 1'b1, 5, rnd128(), 1'b0);
    txn(0, 1, 1'b1, 5, rnd128(), 1'b0);
    txn(0, 0, 1'b0, 5, '0, 1'b0);
    txn(0, 0, 1'b1, 9, rnd128(), 1'b1);
    txn(0, 1, 1'b0, 9, '0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      txn(0, $urandom_range(1, 0), 1'($urandom_range(1, 0)), $urandom_range(15, 0),
          rnd128(), 1'b0);
    end
    fairness(0);

    // WAIT_CYCLES=3: client 1 read with longer latency.
    txn(2, 0, 1'b1, 7, rnd128(), 1'b0);
    txn(2, 1, 1'b0, 7, '0, 1'b0);

    // WAIT_CYCLES=2: reset on the access edge drops the pending write.
    txn(1, 0, 1'b1, 2, rnd128(), 1'b0);
    old2 = mem_m[1][2];
    cs_a[1][0]          = 1'b1;
    we_a[1][0]          = 1'b1;
    addr_a[1][0 +: AW]  = AW'(2);
    wd_a[1][0 +: DW]    = ~old2;
    step(); step(); step();
    chk("pre_rst_busy", busy_a[1], 1);
    chk("pre_rst_ack", ack_a[1], 0);
    areset_a[1] = 1'b1;
    cs_a[1]     = '0;
    step();
    areset_a[1] = 1'b0;
    last_m[1]   = NC - 1;
    chk("mid_rst_ack", ack_a[1], 0);
    chk("mid_rst_busy", busy_a[1], 0);
    chk("mid_rst_rd", rd_a[1], 0);
    chk("mid_rst_gid", gid_a[1], NC - 1);
    step();
    chk("mid_rst_noack", ack_a[1], 0);
    txn(1, 0, 1'b0, 2, '0, 1'b0);
    chk("kept_write", rd_a[1], old2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
